ct_lsu_pfu_mmu_arb: RTL and testbench
=====================================

# ct_lsu_pfu_mmu_arb

Responder side of the PFU prefetch-engine MMU request interface. It arbitrates translation requests from the global prefetch buffer (l1/l2 sources) and the per-entry prefetch buffers (PMB). It holds one outstanding translation on the LSU→MMU va2 port and broadcasts the returned PPN and attributes back to the requester as `pfu_get_*`. One translation is in flight at a time; a global pop kills it.

## Interface
- PMB_NUM, 8, number of PMB requesters (indices 1..PMB_NUM; index 0 = gpfb)
- VPN_W, 28, virtual page number width
- PPN_W, 28, physical page number width

- forever_cpuclk  in  1  single clock
- cpurst  in  1  reset, synchronous, active-high
- cp0_lsu_pfu_mmu_dis  in  1  blocks new grants
- pfu_pop_all_vld  in  1  global prefetch flush
- pfu_gpfb_mmu_pe_req  in  1  gpfb request
- pfu_gpfb_mmu_pe_req_src  in  2  [0] l1 pending, [1] l2 pending
- pfu_gpfb_l1_vpn / pfu_gpfb_l2_vpn  in  VPN_W each  gpfb VPNs
- pfu_gpfb_mmu_pe_req_grnt  out  1  gpfb grant pulse
- pfu_mmu_pe_req_sel_l1  out  1  granted gpfb source is l1
- pfu_pmb_mmu_pe_req  in  PMB_NUM  PMB requests
- pfu_pmb_vpn  in  PMB_NUM*VPN_W  PMB VPNs, entry i at [i*VPN_W +: VPN_W]
- pfu_pmb_mmu_pe_req_grnt  out  PMB_NUM  one-hot grant pulse
- lsu_mmu_va2_vld  out  1  translation request
- lsu_mmu_va2  out  VPN_W  VPN under translation
- mmu_lsu_pa2_vld  in  1  response pulse
- mmu_lsu_pa2  in  PPN_W  PPN
- mmu_lsu_pa2_err / mmu_lsu_sec2 / mmu_lsu_share2  in  1 each  fault, secure, shareable
- pfu_get_ppn_vld  out  1  result pulse
- pfu_get_ppn  out  PPN_W  result PPN
- pfu_get_ppn_err / pfu_get_page_sec / pfu_get_page_share  out  1 each  result attributes
- pfu_get_src  out  PMB_NUM+1  one-hot owner of result (bit 0 = gpfb)

## Operation
- States: IDLE, REQ, KILL.
- IDLE: grant allowed iff any request, !cp0_lsu_pfu_mmu_dis, !pfu_pop_all_vld.
  - Grant is combinational in this cycle. One-hot across gpfb and PMB.
  - Winner is chosen round-robin from pointer `rr_ptr` (index 0..PMB_NUM).
  - On grant: register owner one-hot, register VPN, set `rr_ptr` = winner+1 mod (PMB_NUM+1), go to REQ.
- gpfb VPN select:
  - src[0]=1 → l1_vpn and sel_l1=1.
  - Otherwise l2_vpn and sel_l1=0.
  - sel_l1 is driven only in a gpfb grant cycle; otherwise 0.
  - gpfb req with src=0 is ignored (not eligible).
- REQ: lsu_mmu_va2_vld=1, lsu_mmu_va2 held stable.
  - pa2_vld and !pop → register pa2/err/sec2/share2 and owner into pfu_get_*; pfu_get_ppn_vld=1 next cycle; go IDLE.
  - pa2_vld and pop same cycle → discard, go IDLE.
  - pop without pa2_vld → KILL.
- KILL: va2_vld stays 1 (the MMU request cannot be withdrawn). The next pa2_vld is discarded; go IDLE.
- cp0_lsu_pfu_mmu_dis only blocks grants. An in-flight translation completes normally.
- pfu_get_ppn/attr/src hold their last value between pulses. Only pfu_get_ppn_vld is a pulse.
- Reset: state IDLE, rr_ptr=0. All outputs 0: va2_vld, va2, get_* and grants.

## Timing
- Request seen cycle 0 → grant cycle 0 → va2_vld rises cycle 1.
- pa2_vld at cycle k → pfu_get_ppn_vld at cycle k+1.
- IDLE is re-entered at cycle k+1, so the next grant can occur at k+1 and the next va2_vld at k+2.
- Minimum spacing between consecutive va2 requests: 1 idle cycle.
- Requester must hold req until granted. A request dropped before grant is simply not granted.
- Reset mid-translation: the state machine returns to IDLE and the late pa2_vld is ignored. Any MMU response arriving in IDLE is ignored.

## Structure
- Shared package `ct_lsu_pfu_pkg`:
  - state enum (IDLE/REQ/KILL)
  - VPN_W/PPN_W defaults
  - gpfb src bit positions
- Sub-module `ct_lsu_pfu_rr_arb`:
  - parameterised N-way round-robin arbiter
  - inputs: req vector, enable; output: one-hot grant
  - owns the pointer, which advances on grant

## Test plan
- Reset, then single gpfb req with src=2'b01 and l1_vpn=0x0ABCDEF:
  - grant in the request cycle; sel_l1=1; va2=0x0ABCDEF from cycle 1.
  - pa2_vld with pa2=0x1234567, sec2=1 → next cycle get_ppn_vld=1, ppn=0x1234567, page_sec=1, get_src=1.
- gpfb and PMB[3] requesting continuously, rr_ptr=0: grant order gpfb, PMB3, gpfb, PMB3; no double grant in any cycle.
- pop_all asserted 2 cycles after grant: state KILL; the following pa2_vld produces no get_ppn_vld; a grant is possible the cycle after.
- pop_all and pa2_vld in the same cycle in REQ: no get_ppn_vld; IDLE next cycle.
- cp0_lsu_pfu_mmu_dis=1 with PMB[0] requesting for 10 cycles: no grant. Deassert → grant the same cycle.
- pa2_err=1 response for a PMB[7] request: get_ppn_err=1 and get_src bit 8 set for one pulse.

Source files
------------

// File: rtl/ct_lsu_pfu_pkg.sv
// Shared types and defaults for the PFU prefetch-engine MMU request path.
package ct_lsu_pfu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } pfu_mmu_st_e;

  localparam int VPN_W_DEF = 28;
  localparam int PPN_W_DEF = 28;

  // gpfb request source bits
  localparam int SRC_L1 = 0;
  localparam int SRC_L2 = 1;

endpackage

// File: rtl/ct_lsu_pfu_rr_arb.sv
// N-way round-robin arbiter; the pointer moves to winner+1 whenever a grant is issued.
module ct_lsu_pfu_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic          w_any;

  // Scan from the pointer upward with wrap; the first requester found wins.
  always_comb begin : p_pick
    int idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    o_gnt = '0;
    for (int o = 0; o < N; o++) begin
      idx = int'(r_ptr) + o;
      if (idx >= N) idx = idx - N;
      if (!w_any && i_req[idx]) begin
        w_any = 1'b1;
        w_win = PW'(idx);
      end
    end
    if (i_en && w_any) o_gnt[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (i_en && w_any)
      r_ptr <= (w_win == PW'(N-1)) ? '0 : w_win + 1'b1;
  end

endmodule

// File: rtl/ct_lsu_pfu_mmu_arb.sv
// Arbitrates gpfb/PMB translation requests onto the single LSU va2 port and
// returns the translated PPN and attributes to the owning requester.
module ct_lsu_pfu_mmu_arb
  import ct_lsu_pfu_pkg::*;
#(
  parameter int PMB_NUM = 8,
  parameter int VPN_W   = VPN_W_DEF,
  parameter int PPN_W   = PPN_W_DEF
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     cp0_lsu_pfu_mmu_dis,
  input  logic                     pfu_pop_all_vld,
  input  logic                     pfu_gpfb_mmu_pe_req,
  input  logic [1:0]               pfu_gpfb_mmu_pe_req_src,
  input  logic [VPN_W-1:0]         pfu_gpfb_l1_vpn,
  input  logic [VPN_W-1:0]         pfu_gpfb_l2_vpn,
  output logic                     pfu_gpfb_mmu_pe_req_grnt,
  output logic                     pfu_mmu_pe_req_sel_l1,
  input  logic [PMB_NUM-1:0]       pfu_pmb_mmu_pe_req,
  input  logic [PMB_NUM*VPN_W-1:0] pfu_pmb_vpn,
  output logic [PMB_NUM-1:0]       pfu_pmb_mmu_pe_req_grnt,
  output logic                     lsu_mmu_va2_vld,
  output logic [VPN_W-1:0]         lsu_mmu_va2,
  input  logic                     mmu_lsu_pa2_vld,
  input  logic [PPN_W-1:0]         mmu_lsu_pa2,
  input  logic                     mmu_lsu_pa2_err,
  input  logic                     mmu_lsu_sec2,
  input  logic                     mmu_lsu_share2,
  output logic                     pfu_get_ppn_vld,
  output logic [PPN_W-1:0]         pfu_get_ppn,
  output logic                     pfu_get_ppn_err,
  output logic                     pfu_get_page_sec,
  output logic                     pfu_get_page_share,
  output logic [PMB_NUM:0]         pfu_get_src
);

  localparam int N = PMB_NUM + 1;

  pfu_mmu_st_e      r_state, w_state_nxt;
  logic [N-1:0]     w_req, w_gnt, r_owner;
  logic             w_arb_en, w_fire;
  logic [VPN_W-1:0] w_gpfb_vpn, w_gnt_vpn, r_va2;
  logic             r_get_vld, r_get_err, r_get_sec, r_get_share;
  logic [PPN_W-1:0] r_get_ppn;
  logic [N-1:0]     r_get_src;

  // A gpfb request with no pending source has nothing to translate.
  assign w_req    = {pfu_pmb_mmu_pe_req,
                     pfu_gpfb_mmu_pe_req & (|pfu_gpfb_mmu_pe_req_src)};
  assign w_arb_en = (r_state == ST_IDLE) & ~cp0_lsu_pfu_mmu_dis
                    & ~pfu_pop_all_vld & ~cpurst;

  ct_lsu_pfu_rr_arb #(.N(N)) u_rr_arb (
    .clk   (forever_cpuclk),
    .rst   (cpurst),
    .i_req (w_req),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  assign w_gpfb_vpn = pfu_gpfb_mmu_pe_req_src[SRC_L1] ? pfu_gpfb_l1_vpn
                                                      : pfu_gpfb_l2_vpn;

  always_comb begin
    w_gnt_vpn = '0;
    if (w_gnt[0]) w_gnt_vpn = w_gnt_vpn | w_gpfb_vpn;
    for (int i = 0; i < PMB_NUM; i++)
      if (w_gnt[i+1]) w_gnt_vpn = w_gnt_vpn | pfu_pmb_vpn[i*VPN_W +: VPN_W];
  end

  assign pfu_gpfb_mmu_pe_req_grnt = w_gnt[0];
  assign pfu_mmu_pe_req_sel_l1    = w_gnt[0] & pfu_gpfb_mmu_pe_req_src[SRC_L1];
  assign pfu_pmb_mmu_pe_req_grnt  = w_gnt[N-1:1];

  assign w_fire = (r_state == ST_REQ) & mmu_lsu_pa2_vld & ~pfu_pop_all_vld;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|w_gnt) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (mmu_lsu_pa2_vld)      w_state_nxt = ST_IDLE;
        else if (pfu_pop_all_vld) w_state_nxt = ST_KILL;
      end
      // The MMU request cannot be withdrawn; wait for and drop its response.
      ST_KILL: if (mmu_lsu_pa2_vld) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_va2       <= '0;
      r_owner     <= '0;
      r_get_vld   <= 1'b0;
      r_get_ppn   <= '0;
      r_get_err   <= 1'b0;
      r_get_sec   <= 1'b0;
      r_get_share <= 1'b0;
      r_get_src   <= '0;
    end else begin
      if (|w_gnt) begin
        r_va2   <= w_gnt_vpn;
        r_owner <= w_gnt;
      end
      r_get_vld <= w_fire;
      if (w_fire) begin
        r_get_ppn   <= mmu_lsu_pa2;
        r_get_err   <= mmu_lsu_pa2_err;
        r_get_sec   <= mmu_lsu_sec2;
        r_get_share <= mmu_lsu_share2;
        r_get_src   <= r_owner;
      end
    end
  end

  assign lsu_mmu_va2_vld    = (r_state != ST_IDLE);
  assign lsu_mmu_va2        = r_va2;
  assign pfu_get_ppn_vld    = r_get_vld;
  assign pfu_get_ppn        = r_get_ppn;
  assign pfu_get_ppn_err    = r_get_err;
  assign pfu_get_page_sec   = r_get_sec;
  assign pfu_get_page_share = r_get_share;
  assign pfu_get_src        = r_get_src;

endmodule

// File: tb/tb_ct_lsu_pfu_mmu_arb.sv
// Directed bench for ct_lsu_pfu_mmu_arb: grant timing, round-robin order, pop/kill,
// disable gating, error response and reset recovery.
module tb_ct_lsu_pfu_mmu_arb;

  localparam int PMB_NUM = 8;
  localparam int VPN_W   = 28;
  localparam int PPN_W   = 28;

  logic                     clk = 1'b0;
  logic                     cpurst;
  logic                     dis, pop;
  logic                     gpfb_req;
  logic [1:0]               gpfb_src;
  logic [VPN_W-1:0]         l1_vpn, l2_vpn;
  logic                     gpfb_grnt, sel_l1;
  logic [PMB_NUM-1:0]       pmb_req, pmb_grnt;
  logic [PMB_NUM*VPN_W-1:0] pmb_vpn;
  logic                     va2_vld;
  logic [VPN_W-1:0]         va2;
  logic                     pa2_vld, pa2_err, sec2, share2;
  logic [PPN_W-1:0]         pa2;
  logic                     get_vld, get_err, get_sec, get_share;
  logic [PPN_W-1:0]         get_ppn;
  logic [PMB_NUM:0]         get_src;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ct_lsu_pfu_mmu_arb #(.PMB_NUM(PMB_NUM), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
    .forever_cpuclk           (clk),
    .cpurst                   (cpurst),
    .cp0_lsu_pfu_mmu_dis      (dis),
    .pfu_pop_all_vld          (pop),
    .pfu_gpfb_mmu_pe_req      (gpfb_req),
    .pfu_gpfb_mmu_pe_req_src  (gpfb_src),
    .pfu_gpfb_l1_vpn          (l1_vpn),
    .pfu_gpfb_l2_vpn          (l2_vpn),
    .pfu_gpfb_mmu_pe_req_grnt (gpfb_grnt),
    .pfu_mmu_pe_req_sel_l1    (sel_l1),
    .pfu_pmb_mmu_pe_req       (pmb_req),
    .pfu_pmb_vpn              (pmb_vpn),
    .pfu_pmb_mmu_pe_req_grnt  (pmb_grnt),
    .lsu_mmu_va2_vld          (va2_vld),
    .lsu_mmu_va2              (va2),
    .mmu_lsu_pa2_vld          (pa2_vld),
    .mmu_lsu_pa2              (pa2),
    .mmu_lsu_pa2_err          (pa2_err),
    .mmu_lsu_sec2             (sec2),
    .mmu_lsu_share2           (share2),
    .pfu_get_ppn_vld          (get_vld),
    .pfu_get_ppn              (get_ppn),
    .pfu_get_ppn_err          (get_err),
    .pfu_get_page_sec         (get_sec),
    .pfu_get_page_share       (get_share),
    .pfu_get_src              (get_src)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cpurst = 1'b1;
    tick();
    tick();
    cpurst = 1'b0;
  endtask

  initial begin
    cpurst = 1'b1; dis = 0; pop = 0; gpfb_req = 0; gpfb_src = 0;
    l1_vpn = 0; l2_vpn = 0; pmb_req = 0; pmb_vpn = '0;
    pa2_vld = 0; pa2 = 0; pa2_err = 0; sec2 = 0; share2 = 0;

    // reset state; a request during reset must not be granted
    tick();
    gpfb_req = 1; gpfb_src = 2'b01; l1_vpn = 28'h0ABCDEF; l2_vpn = 28'h5555555;
    settle();
    chk("rst_grnt", {gpfb_grnt, pmb_grnt}, 0);
    chk("rst_va2_vld", va2_vld, 0);
    chk("rst_va2", va2, 0);
    chk("rst_get", {get_vld, get_ppn, get_err, get_sec, get_share, get_src}, 0);
    tick();
    cpurst = 1'b0;

    // single gpfb l1 request
    settle();
    chk("t1_grnt", gpfb_grnt, 1);
    chk("t1_sel_l1", sel_l1, 1);
    chk("t1_pmb_grnt", pmb_grnt, 0);
    chk("t1_va2_vld_c0", va2_vld, 0);
    tick();
    gpfb_req = 0;
    settle();
    chk("t1_va2_vld_c1", va2_vld, 1);
    chk("t1_va2", va2, 28'h0ABCDEF);
    chk("t1_sel_l1_off", sel_l1, 0);
    pa2_vld = 1; pa2 = 28'h1234567; sec2 = 1;
    settle();
    chk("t1_get_vld_early", get_vld, 0);
    tick();
    pa2_vld = 0; sec2 = 0;
    settle();
    chk("t1_get_vld", get_vld, 1);
    chk("t1_get_ppn", get_ppn, 28'h1234567);
    chk("t1_get_sec", get_sec, 1);
    chk("t1_get_err_share", {get_err, get_share}, 0);
    chk("t1_get_src", get_src, 9'h001);
    chk("t1_va2_vld_done", va2_vld, 0);
    tick();
    settle();
    chk("t1_get_vld_pulse", get_vld, 0);
    chk("t1_get_ppn_hold", get_ppn, 28'h1234567);

    // round-robin gpfb(l2) vs PMB[3] from pointer 0
    do_reset();
    gpfb_req = 1; gpfb_src = 2'b10; l2_vpn = 28'h2222222;
    pmb_req = 8'h08; pmb_vpn[3*VPN_W +: VPN_W] = 28'h3333333;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t2_gpfb_grnt%0d", k), gpfb_grnt, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t2_pmb_grnt%0d", k), pmb_grnt, (k % 2 == 0) ? 8'h00 : 8'h08);
      chk($sformatf("t2_sel_l1_%0d", k), sel_l1, 0);
      tick();
      settle();
      chk($sformatf("t2_va2_%0d", k), va2, (k % 2 == 0) ? 28'h2222222 : 28'h3333333);
      chk($sformatf("t2_req_nogrnt%0d", k), {gpfb_grnt, pmb_grnt}, 0);
      pa2_vld = 1; pa2 = 28'h100 + 28'(k);
      tick();
      pa2_vld = 0;
      if (k == 3) begin gpfb_req = 0; pmb_req = 0; end
      settle();
      chk($sformatf("t2_get_src%0d", k), get_src, (k % 2 == 0) ? 9'h001 : 9'h010);
      chk($sformatf("t2_get_ppn%0d", k), get_ppn, 28'h100 + 28'(k));
    end

    // pop two cycles after grant -> KILL, response dropped
    gpfb_req = 1; gpfb_src = 2'b01; l1_vpn = 28'h0111111;
    settle();
    chk("t3_grnt", gpfb_grnt, 1);
    tick();
    gpfb_req = 0;
    tick();
    pop = 1;
    settle();
    chk("t3_va2_vld_pop", va2_vld, 1);
    tick();
    pop = 0;
    settle();
    chk("t3_kill_va2_vld", va2_vld, 1);
    pmb_req = 8'h01; pmb_vpn[0 +: VPN_W] = 28'h0F0F0F0; pa2_vld = 1; pa2 = 28'h999;
    settle();
    chk("t3_kill_nogrnt", pmb_grnt, 0);
    tick();
    pa2_vld = 0;
    settle();
    chk("t3_no_get", get_vld, 0);
    chk("t3_regrant", pmb_grnt, 8'h01);
    tick();
    pmb_req = 0;
    settle();
    chk("t3_va2", va2, 28'h0F0F0F0);
    pa2_vld = 1; pa2 = 28'h5A5A5A5;
    tick();
    pa2_vld = 0;
    settle();
    chk("t3_get_vld", get_vld, 1);
    chk("t3_get_src", get_src, 9'h002);

    // pop and pa2_vld together in REQ
    pmb_req = 8'h02; pmb_vpn[1*VPN_W +: VPN_W] = 28'h4444444;
    settle();
    chk("t4_grnt", pmb_grnt, 8'h02);
    tick();
    pmb_req = 0; pa2_vld = 1; pop = 1; pa2 = 28'hDEAD;
    tick();
    pa2_vld = 0; pop = 0;
    settle();
    chk("t4_no_get", get_vld, 0);
    chk("t4_idle", va2_vld, 0);
    chk("t4_ppn_hold", get_ppn, 28'h5A5A5A5);

    // stray response while idle
    pa2_vld = 1; pa2 = 28'h111;
    tick();
    pa2_vld = 0;
    settle();
    chk("t4_idle_resp", {get_vld, get_ppn}, {1'b0, 28'h5A5A5A5});

    // disable blocks grants but not an in-flight translation
    dis = 1; pmb_req = 8'h01;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("t5_dis%0d", c), {va2_vld, pmb_grnt}, 0);
      tick();
    end
    dis = 0;
    settle();
    chk("t5_grnt", pmb_grnt, 8'h01);
    tick();
    pmb_req = 0; dis = 1; pa2_vld = 1; pa2 = 28'h7654321;
    tick();
    pa2_vld = 0; dis = 0;
    settle();
    chk("t5_get_vld", get_vld, 1);
    chk("t5_get_ppn", get_ppn, 28'h7654321);

    // error response for PMB[7]
    pmb_req = 8'h80; pmb_vpn[7*VPN_W +: VPN_W] = 28'hFEDCBA9;
    settle();
    chk("t6_grnt", pmb_grnt, 8'h80);
    tick();
    pmb_req = 0;
    settle();
    chk("t6_va2", va2, 28'hFEDCBA9);
    pa2_vld = 1; pa2_err = 1; pa2 = 28'h42;
    tick();
    pa2_vld = 0; pa2_err = 0;
    settle();
    chk("t6_get_vld", get_vld, 1);
    chk("t6_get_err", get_err, 1);
    chk("t6_get_src", get_src, 9'h100);
    chk("t6_get_ppn", get_ppn, 28'h42);
    tick();
    settle();
    chk("t6_pulse", get_vld, 0);
    chk("t6_src_hold", get_src, 9'h100);

    // reset mid-translation; late response ignored
    gpfb_req = 1; gpfb_src = 2'b01; l1_vpn = 28'h0C0FFEE;
    settle();
    chk("t7_grnt", gpfb_grnt, 1);
    tick();
    gpfb_req = 0; cpurst = 1;
    tick();
    cpurst = 0;
    settle();
    chk("t7_rst_state", {va2_vld, va2, get_src}, 0);
    pa2_vld = 1; pa2 = 28'h333;
    tick();
    pa2_vld = 0;
    settle();
    chk("t7_late_resp", {get_vld, get_ppn}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
